pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Parametrised hazard and pipeline-control unit for the next-generation integer pipeline. It replaces the fixed single-stage register-compare hazard check and the branch-only flush with one block. The block tracks every in-flight writer over a configurable number of post-ID stages and produces forwarding selects for both source operands. It also generates load-use stalls/bubbles, IF/ID flush on taken branch, and a request/acknowledge handshake to a variable-latency data memory with timeout. It sits beside the ID stage and drives PC hold, IF/ID hold/flush, the ID/EX bubble and the forwarding muxes.

## Interface
- REG_ADDRESS_LENGTH, 5, register address width
- FWD_STAGES, 2, tracked post-ID stages (EX = entry 0 … WB = entry FWD_STAGES-1), legal 1..7
- LOAD_USE_STALL, 0, 1 = load result not forwardable from entry 0, stall one cycle
- ZERO_REG_HARDWIRED, 1, 1 = register 0 never matches (never forwarded or stalled on)
- MEM_TIMEOUT, 15, wait cycles before a pending memory access is force-completed, legal ≥1

- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- id_valid  input  1  ID holds a real instruction
- id_ra, id_rb  input  REG_ADDRESS_LENGTH  ID source addresses
- id_ra_used, id_rb_used  input  1  source actually read
- id_rd  input  REG_ADDRESS_LENGTH  ID destination
- id_wen  input  1  ID instruction writes id_rd
- id_is_load, id_is_mem  input  1  load / any data-memory access
- branch_taken  input  1  branch resolved taken in ID
- dmem_ack  input  1  memory completes access of entry 0
- stall_pc  output  1  hold PC
- stall_ifid  output  1  hold IF/ID register
- flush_ifid  output  1  clear IF/ID register to 0
- bubble_ex  output  1  load NOP into ID/EX
- hold_ex  output  1  hold ID/EX and all later stage registers
- fwd_sel_a, fwd_sel_b  output  3  0 = register file, k = entry k-1 result
- dmem_req  output  1  access request for entry 0
- mem_err  output  1  sticky timeout flag
- wait_cnt  output  4  current wait cycles, saturating at 15

## Operation
- Tracker: FWD_STAGES entries {valid, wen, rd, is_load, is_mem}. On advance, entry k ← entry k-1, entry 0 ← ID info if id_valid & ~hazard_stall, else invalid (bubble).
- Match(k,src): entry k valid & wen & rd==src & src_used & ~(ZERO_REG_HARDWIRED & src==0).
- fwd_sel: smallest k with match(k-1); youngest wins; 0 if none. Combinational.
- hazard_stall = LOAD_USE_STALL & entry0.is_load & (match(0,ra)|match(0,rb)) & id_valid. Effect: stall_pc=stall_ifid=bubble_ex=1; tracker advances.
- Memory FSM, states IDLE / WAIT:
  - IDLE: dmem_req = entry0.valid & entry0.is_mem. With req and dmem_ack, advance normally. With req and no ack, go to WAIT; mem_stall=1.
  - WAIT: dmem_req=1, mem_stall=1, wait_cnt increments each cycle. On dmem_ack, complete and go to IDLE with wait_cnt←0. If wait_cnt reaches MEM_TIMEOUT without ack, force-complete, set mem_err, and go to IDLE.
- mem_stall: hold_ex=stall_pc=stall_ifid=1, bubble_ex=0, and the tracker holds. It overrides hazard_stall; fwd_sel is still computed from held state.
- flush_ifid = branch_taken & ~mem_stall & ~hazard_stall. A branch stalled by either hazard re-evaluates once released.
- branch_taken and a hazard in the same cycle: stall wins, no flush.
- mem_err clears only on rst.

## Timing
- All control outputs are combinational from tracker/FSM state plus the current-cycle inputs. There are no registered-output delays.
- Forwarding latency is 0: a writer in entry k is visible to ID in the same cycle.
- Load-use penalty: exactly 1 bubble when LOAD_USE_STALL=1, otherwise 0.
- Memory: ack in the request cycle means 0 stall cycles. Ack N cycles later means N stall cycles. Timeout means exactly MEM_TIMEOUT stall cycles.
- Reset (any cycle, including mid-WAIT): entries invalid, FSM IDLE, wait_cnt=0, mem_err=0. All outputs are then 0 and fwd_sel=0. dmem_req drops in the cycle after rst is sampled.

## Test plan
- Back-to-back dependency, FWD_STAGES=2: ID writes r3, next ID reads r3 as ra → fwd_sel_a=1; one cycle later a reader of r3 gets fwd_sel_a=2. An intermediate writer of r3 overrides to 1. An id_rd=0 writer gives fwd_sel=0.
- Load-use, LOAD_USE_STALL=1: load r5, then reader of r5 as rb → one cycle of stall_pc=stall_ifid=bubble_ex=1, then fwd_sel_b=2. With LOAD_USE_STALL=0 there is no stall and fwd_sel_b=1.
- Memory wait: store in entry 0, dmem_ack after 3 cycles → dmem_req high for 4 cycles, hold_ex=1 for 3 cycles, wait_cnt 0→1→2→3→0, no bubble inserted.
- Timeout, MEM_TIMEOUT=4, ack never asserted → 4 stall cycles, then mem_err=1 (sticky) and pipeline advances.
- branch_taken during WAIT → flush_ifid=0 until ack. In the ack-completion cycle, flush_ifid=1 if branch_taken is still asserted.
- rst asserted mid-WAIT with wait_cnt=2 → next cycle dmem_req=0, wait_cnt=0, mem_err=0, all fwd_sel=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Writer tracker with operand forwarding selects, load-use stall,
//            IF/ID flush and data-memory request/ack handshake with timeout.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int REG_ADDRESS_LENGTH = 5,
    parameter int FWD_STAGES         = 2,
    parameter int LOAD_USE_STALL     = 0,
    parameter int ZERO_REG_HARDWIRED = 1,
    parameter int MEM_TIMEOUT        = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_valid,
    input  logic [REG_ADDRESS_LENGTH-1:0] id_ra,
    input  logic [REG_ADDRESS_LENGTH-1:0] id_rb,
    input  logic                          id_ra_used,
    input  logic                          id_rb_used,
    input  logic [REG_ADDRESS_LENGTH-1:0] id_rd,
    input  logic                          id_wen,
    input  logic                          id_is_load,
    input  logic                          id_is_mem,
    input  logic                          branch_taken,
    input  logic                          dmem_ack,
    output logic                          stall_pc,
    output logic                          stall_ifid,
    output logic                          flush_ifid,
    output logic                          bubble_ex,
    output logic                          hold_ex,
    output logic [2:0]                    fwd_sel_a,
    output logic [2:0]                    fwd_sel_b,
    output logic                          dmem_req,
    output logic                          mem_err,
    output logic [3:0]                    wait_cnt
);

    localparam int c_cnt_w = (MEM_TIMEOUT > 15) ? $clog2(MEM_TIMEOUT + 1) : 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

    // Tracker entries; load/mem attributes only matter while in entry 0.
    logic [FWD_STAGES-1:0]         r_valid;
    logic [FWD_STAGES-1:0]         r_wen;
    logic [REG_ADDRESS_LENGTH-1:0] r_rd [FWD_STAGES];
    logic                          r_e0_is_load;
    logic                          r_e0_is_mem;

    mem_state_t                    r_state;
    logic [c_cnt_w-1:0]            r_wait_cnt;
    logic                          r_mem_err;

    logic [FWD_STAGES-1:0]         w_match_a;
    logic [FWD_STAGES-1:0]         w_match_b;
    logic                          w_ra_ok;
    logic                          w_rb_ok;
    logic                          w_hazard_raw;
    logic                          w_hazard;
    logic                          w_mem_idle_req;
    logic                          w_timeout;
    logic                          w_mem_stall;
    logic                          w_load_id;

    assign w_ra_ok = id_ra_used & ~((ZERO_REG_HARDWIRED != 0) && (id_ra == '0));
    assign w_rb_ok = id_rb_used & ~((ZERO_REG_HARDWIRED != 0) && (id_rb == '0));

    for (genvar k = 0; k < FWD_STAGES; k++) begin : g_match
        assign w_match_a[k] = r_valid[k] & r_wen[k] & (r_rd[k] == id_ra) & w_ra_ok;
        assign w_match_b[k] = r_valid[k] & r_wen[k] & (r_rd[k] == id_rb) & w_rb_ok;
    end

    // Scan oldest to youngest so the youngest matching writer wins.
    always_comb begin
        fwd_sel_a = 3'd0;
        fwd_sel_b = 3'd0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (w_match_a[k]) fwd_sel_a = 3'(k + 1);
            if (w_match_b[k]) fwd_sel_b = 3'(k + 1);
        end
    end

    assign w_hazard_raw   = (LOAD_USE_STALL != 0) & r_e0_is_load
                          & (w_match_a[0] | w_match_b[0]) & id_valid;
    assign w_mem_idle_req = r_valid[0] & r_e0_is_mem;
    assign w_timeout      = (r_wait_cnt >= c_cnt_w'(MEM_TIMEOUT));
    // The completion cycle (ack or timeout) is not a stall cycle.
    assign w_mem_stall    = (r_state == ST_IDLE) ? (w_mem_idle_req & ~dmem_ack)
                                                 : ~(dmem_ack | w_timeout);
    assign w_hazard       = w_hazard_raw & ~w_mem_stall;
    assign w_load_id      = id_valid & ~w_hazard;

    assign stall_pc   = w_mem_stall | w_hazard;
    assign stall_ifid = w_mem_stall | w_hazard;
    assign bubble_ex  = w_hazard;
    assign hold_ex    = w_mem_stall;
    assign flush_ifid = branch_taken & ~w_mem_stall & ~w_hazard;
    assign dmem_req   = (r_state == ST_WAIT) ? 1'b1 : w_mem_idle_req;
    assign mem_err    = r_mem_err;
    assign wait_cnt   = (r_wait_cnt > c_cnt_w'(15)) ? 4'd15 : r_wait_cnt[3:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= '0;
            r_wen        <= '0;
            r_e0_is_load <= 1'b0;
            r_e0_is_mem  <= 1'b0;
            for (int k = 0; k < FWD_STAGES; k++) begin
                r_rd[k] <= '0;
            end
        end else if (!w_mem_stall) begin
            for (int k = FWD_STAGES - 1; k >= 1; k--) begin
                r_valid[k] <= r_valid[k-1];
                r_wen[k]   <= r_wen[k-1];
                r_rd[k]    <= r_rd[k-1];
            end
            r_valid[0]   <= w_load_id;
            r_wen[0]     <= id_wen;
            r_rd[0]      <= id_rd;
            r_e0_is_load <= id_is_load;
            r_e0_is_mem  <= id_is_mem;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (w_mem_idle_req && !dmem_ack) begin
                r_state    <= ST_WAIT;
                r_wait_cnt <= c_cnt_w'(1);
            end
        end else begin
            if (dmem_ack) begin
                r_state    <= ST_IDLE;
                r_wait_cnt <= '0;
            end else if (w_timeout) begin
                r_state    <= ST_IDLE;
                r_wait_cnt <= '0;
                r_mem_err  <= 1'b1;
            end else begin
                r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Directed vector table plus load-use sequence for pipe_hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    typedef struct {
        logic       rst;
        logic       v;
        logic [4:0] ra;
        logic       rau;
        logic [4:0] rb;
        logic       rbu;
        logic [4:0] rd;
        logic       wen;
        logic       ld;
        logic       mem;
        logic       br;
        logic       ack;
    } in_t;

    typedef struct {
        logic [2:0] fa;
        logic [2:0] fb;
        logic       stall;
        logic       flush;
        logic       bub;
        logic       hold;
        logic       req;
        logic       err;
        logic [3:0] wc;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_ra_used, id_rb_used, id_wen, id_is_load, id_is_mem;
    logic       branch_taken, dmem_ack;
    logic [4:0] id_ra, id_rb, id_rd;

    logic       a_stall_pc, a_stall_ifid, a_flush, a_bubble, a_hold, a_req, a_err;
    logic [2:0] a_fa, a_fb;
    logic [3:0] a_wc;
    logic       b_stall_pc, b_stall_ifid, b_flush, b_bubble, b_hold, b_req, b_err;
    logic [2:0] b_fa, b_fb;
    logic [3:0] b_wc;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REG_ADDRESS_LENGTH(5), .FWD_STAGES(2), .LOAD_USE_STALL(1),
        .ZERO_REG_HARDWIRED(1), .MEM_TIMEOUT(4)
    ) u_dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
        .id_ra_used(id_ra_used), .id_rb_used(id_rb_used), .id_rd(id_rd),
        .id_wen(id_wen), .id_is_load(id_is_load), .id_is_mem(id_is_mem),
        .branch_taken(branch_taken), .dmem_ack(dmem_ack),
        .stall_pc(a_stall_pc), .stall_ifid(a_stall_ifid), .flush_ifid(a_flush),
        .bubble_ex(a_bubble), .hold_ex(a_hold), .fwd_sel_a(a_fa), .fwd_sel_b(a_fb),
        .dmem_req(a_req), .mem_err(a_err), .wait_cnt(a_wc)
    );

    pipe_hazard_ctrl #(
        .REG_ADDRESS_LENGTH(5), .FWD_STAGES(2), .LOAD_USE_STALL(0),
        .ZERO_REG_HARDWIRED(1), .MEM_TIMEOUT(15)
    ) u_dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
        .id_ra_used(id_ra_used), .id_rb_used(id_rb_used), .id_rd(id_rd),
        .id_wen(id_wen), .id_is_load(id_is_load), .id_is_mem(id_is_mem),
        .branch_taken(branch_taken), .dmem_ack(dmem_ack),
        .stall_pc(b_stall_pc), .stall_ifid(b_stall_ifid), .flush_ifid(b_flush),
        .bubble_ex(b_bubble), .hold_ex(b_hold), .fwd_sel_a(b_fa), .fwd_sel_b(b_fb),
        .dmem_req(b_req), .mem_err(b_err), .wait_cnt(b_wc)
    );

    function automatic in_t mi(input logic r, input logic v, input logic [4:0] ra,
                               input logic rau, input logic [4:0] rb, input logic rbu,
                               input logic [4:0] rd, input logic wen, input logic ld,
                               input logic mem, input logic br, input logic ack);
        in_t x;
        x.rst = r; x.v = v; x.ra = ra; x.rau = rau; x.rb = rb; x.rbu = rbu;
        x.rd = rd; x.wen = wen; x.ld = ld; x.mem = mem; x.br = br; x.ack = ack;
        return x;
    endfunction

    function automatic exp_t me(input logic [2:0] fa, input logic [2:0] fb,
                                input logic stall, input logic flush, input logic bub,
                                input logic hold, input logic req, input logic err,
                                input logic [3:0] wc);
        exp_t x;
        x.fa = fa; x.fb = fb; x.stall = stall; x.flush = flush; x.bub = bub;
        x.hold = hold; x.req = req; x.err = err; x.wc = wc;
        return x;
    endfunction

    task automatic apply(input in_t x);
        rst = x.rst; id_valid = x.v; id_ra = x.ra; id_ra_used = x.rau;
        id_rb = x.rb; id_rb_used = x.rbu; id_rd = x.rd; id_wen = x.wen;
        id_is_load = x.ld; id_is_mem = x.mem; branch_taken = x.br; dmem_ack = x.ack;
    endtask

    task automatic chk(input string nm, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0d, expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic chk_a(input int idx, input exp_t e);
        chk("fwd_sel_a", idx, 8'(a_fa), 8'(e.fa));
        chk("fwd_sel_b", idx, 8'(a_fb), 8'(e.fb));
        chk("stall_pc", idx, 8'(a_stall_pc), 8'(e.stall));
        chk("stall_ifid", idx, 8'(a_stall_ifid), 8'(e.stall));
        chk("flush_ifid", idx, 8'(a_flush), 8'(e.flush));
        chk("bubble_ex", idx, 8'(a_bubble), 8'(e.bub));
        chk("hold_ex", idx, 8'(a_hold), 8'(e.hold));
        chk("dmem_req", idx, 8'(a_req), 8'(e.req));
        chk("mem_err", idx, 8'(a_err), 8'(e.err));
        chk("wait_cnt", idx, 8'(a_wc), 8'(e.wc));
    endtask

    localparam int NV = 28;
    vec_t vecs [NV];

    initial begin
        // Forwarding: two r3 writers, youngest wins, zero register ignored.
        vecs[0]  = '{mi(0,0,0,0,0,0,0,0,0,0,0,0), me(0,0,0,0,0,0,0,0,0)};
        vecs[1]  = '{mi(0,1,0,0,0,0,3,1,0,0,0,0), me(0,0,0,0,0,0,0,0,0)};
        vecs[2]  = '{mi(0,1,3,1,0,0,3,1,0,0,0,0), me(1,0,0,0,0,0,0,0,0)};
        vecs[3]  = '{mi(0,1,3,1,3,1,0,0,0,0,0,0), me(1,1,0,0,0,0,0,0,0)};
        vecs[4]  = '{mi(0,1,3,0,3,1,0,0,0,0,0,0), me(0,2,0,0,0,0,0,0,0)};
        vecs[5]  = '{mi(0,1,0,0,0,0,0,1,0,0,0,0), me(0,0,0,0,0,0,0,0,0)};
        vecs[6]  = '{mi(0,1,0,1,0,0,0,0,0,0,0,0), me(0,0,0,0,0,0,0,0,0)};
        // Load-use with same-cycle ack; branch held off by the stall.
        vecs[7]  = '{mi(0,1,0,0,0,0,5,1,1,1,0,0), me(0,0,0,0,0,0,0,0,0)};
        vecs[8]  = '{mi(0,1,0,0,5,1,0,0,0,0,1,1), me(0,1,1,0,1,0,1,0,0)};
        vecs[9]  = '{mi(0,1,0,0,5,1,0,0,0,0,1,0), me(0,2,0,1,0,0,0,0,0)};
        // Store acked after 3 wait cycles, branch during the wait.
        vecs[10] = '{mi(0,1,0,0,0,0,0,0,0,1,0,0), me(0,0,0,0,0,0,0,0,0)};
        vecs[11] = '{mi(0,1,0,0,0,0,7,1,0,0,0,0), me(0,0,1,0,0,1,1,0,0)};
        vecs[12] = '{mi(0,1,0,0,0,0,7,1,0,0,0,0), me(0,0,1,0,0,1,1,0,1)};
        vecs[13] = '{mi(0,1,0,0,0,0,7,1,0,0,1,0), me(0,0,1,0,0,1,1,0,2)};
        vecs[14] = '{mi(0,1,0,0,0,0,7,1,0,0,1,1), me(0,0,0,1,0,0,1,0,3)};
        vecs[15] = '{mi(0,1,7,1,0,0,0,0,0,0,0,0), me(1,0,0,0,0,0,0,0,0)};
        // Timeout after 4 stall cycles, sticky error.
        vecs[16] = '{mi(0,1,0,0,0,0,0,0,0,1,0,0), me(0,0,0,0,0,0,0,0,0)};
        vecs[17] = '{mi(0,0,0,0,0,0,0,0,0,0,0,0), me(0,0,1,0,0,1,1,0,0)};
        vecs[18] = '{mi(0,0,0,0,0,0,0,0,0,0,0,0), me(0,0,1,0,0,1,1,0,1)};
        vecs[19] = '{mi(0,0,0,0,0,0,0,0,0,0,0,0), me(0,0,1,0,0,1,1,0,2)};
        vecs[20] = '{mi(0,0,0,0,0,0,0,0,0,0,0,0), me(0,0,1,0,0,1,1,0,3)};
        vecs[21] = '{mi(0,0,0,0,0,0,0,0,0,0,0,0), me(0,0,0,0,0,0,1,0,4)};
        vecs[22] = '{mi(0,0,0,0,0,0,0,0,0,0,0,0), me(0,0,0,0,0,0,0,1,0)};
        // Reset in the middle of a wait.
        vecs[23] = '{mi(0,1,0,0,0,0,0,0,0,1,0,0), me(0,0,0,0,0,0,0,1,0)};
        vecs[24] = '{mi(0,0,0,0,0,0,0,0,0,0,0,0), me(0,0,1,0,0,1,1,1,0)};
        vecs[25] = '{mi(0,0,0,0,0,0,0,0,0,0,0,0), me(0,0,1,0,0,1,1,1,1)};
        vecs[26] = '{mi(1,0,0,0,0,0,0,0,0,0,0,0), me(0,0,1,0,0,1,1,1,2)};
        vecs[27] = '{mi(0,1,3,1,5,1,0,0,0,0,0,0), me(0,0,0,0,0,0,0,0,0)};

        apply(mi(1,0,0,0,0,0,0,0,0,0,0,0));
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            apply(vecs[i].i);
            #1;
            chk_a(i, vecs[i].e);
        end

        // Load-use: stalling vs non-stalling configurations side by side.
        @(negedge clk);
        apply(mi(1,0,0,0,0,0,0,0,0,0,0,0));
        @(negedge clk);
        apply(mi(0,1,0,0,0,0,5,1,1,0,0,0));
        @(negedge clk);
        apply(mi(0,1,0,0,5,1,0,0,0,0,1,0));
        #1;
        chk("lu_a_stall", 100, 8'(a_stall_pc), 8'd1);
        chk("lu_a_bubble", 100, 8'(a_bubble), 8'd1);
        chk("lu_a_flush", 100, 8'(a_flush), 8'd0);
        chk("lu_b_stall", 100, 8'(b_stall_pc), 8'd0);
        chk("lu_b_bubble", 100, 8'(b_bubble), 8'd0);
        chk("lu_b_flush", 100, 8'(b_flush), 8'd1);
        chk("lu_b_fwd_b", 100, 8'(b_fb), 8'd1);
        @(negedge clk);
        apply(mi(0,1,0,0,5,1,0,0,0,0,1,0));
        #1;
        chk("lu_a_stall2", 101, 8'(a_stall_pc), 8'd0);
        chk("lu_a_fwd_b2", 101, 8'(a_fb), 8'd2);
        chk("lu_a_flush2", 101, 8'(a_flush), 8'd1);
        chk("lu_b_fwd_b2", 101, 8'(b_fb), 8'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
